// File: rtl/grad_pkg.sv
// Shared definitions for the gradient output path.
// Holds the scheduler FSM state encoding, the channel count and channel
// index width, and the word layout fields that grad_bram already uses.
package grad_pkg;

  localparam int N_CHAN = 4;
  localparam int CH_W   = 2;

  // Scheduler FSM encoding (2-bit)
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  // Gradient word layout shared with grad_bram
  localparam int DELAY_MSB = 29;
  localparam int DELAY_LSB = 27;
  localparam int DATA_MSB  = 23;
  localparam int DATA_LSB  = 0;

endpackage

// File: rtl/grad_rr_pick.sv
// Round-robin picker for the serialiser scheduler (purely combinational).
// Ports:
//   pend - per-channel pending flags
//   last - channel served most recently
//   sel  - first pending channel after last, wrapping modulo N_CHAN
//   any  - at least one channel is pending (sel is only meaningful then)
module grad_rr_pick
  import grad_pkg::*;
(
  input  logic [N_CHAN-1:0] pend,
  input  logic [CH_W-1:0]   last,
  output logic [CH_W-1:0]   sel,
  output logic              any
);

  logic [CH_W-1:0] idx;
  logic            found;

  assign any = |pend;

  // Scan last+1, last+2, ... last+N_CHAN; the final step wraps to last
  // itself so a lone pending channel equal to last is still picked.
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= N_CHAN; i++) begin
      idx = last + CH_W'(i);
      if (!found && pend[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/grad_ser_sched.sv
// Scheduler between grad_bram and one shared SPI serialiser.
// Latches per-channel words from grad_bram, then hands them to the
// serialiser one channel at a time in round-robin order.
// Ports:
//   S_AXI_ACLK / S_AXI_ARESETN - clock, synchronous active-low reset
//   data_i, valid_i            - word and per-channel valid pulses from grad_bram
//   ser_busy_i                 - serialiser busy (accept .. shift complete)
//   ser_start_o                - 1-cycle start pulse to the serialiser
//   ser_data_o, ser_chan_o     - word and channel handed to the serialiser
//   serial_busy_o              - to grad_bram: anything pending or in flight
//   data_lost_o                - 1-cycle pulse: a pending word was overwritten
//   pending_o                  - per-channel pending flags (status)
//   ack_err_o                  - sticky: serialiser never acknowledged a start
// Handshake: a start is a single-cycle ser_start_o pulse; the serialiser
// acknowledges by raising ser_busy_i within ACK_TIMEOUT cycles of the pulse
// and signals completion by dropping it. ser_data_o/ser_chan_o hold from
// dispatch until the next dispatch.
module grad_ser_sched
  import grad_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int CHANNELS    = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [CHANNELS-1:0]   valid_i,
  input  logic                  ser_busy_i,
  output logic                  ser_start_o,
  output logic [DATA_WIDTH-1:0] ser_data_o,
  output logic [CH_W-1:0]       ser_chan_o,
  output logic                  serial_busy_o,
  output logic                  data_lost_o,
  output logic [CHANNELS-1:0]   pending_o,
  output logic                  ack_err_o
);

  localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  state_t                state;
  logic [DATA_WIDTH-1:0] hold [CHANNELS];
  logic [CHANNELS-1:0]   pend;
  logic [CH_W-1:0]       last;
  logic [CH_W-1:0]       sel;
  logic                  any;
  logic [TW-1:0]         timer;
  logic                  dispatch;
  logic [CHANNELS-1:0]   disp_mask;
  logic [CHANNELS-1:0]   lost_mask;

  grad_rr_pick u_pick (
    .pend (pend),
    .last (last),
    .sel  (sel),
    .any  (any)
  );

  // A channel being dispatched on this edge is free to accept a new word,
  // so it is excluded from loss detection.
  always_comb begin
    dispatch  = (state == ST_IDLE) && any && !ser_busy_i;
    disp_mask = dispatch ? (CHANNELS'(1) << sel) : '0;
    lost_mask = valid_i & pend & ~disp_mask;
  end

  assign serial_busy_o = (state != ST_IDLE) | (|pend);
  assign pending_o     = pend;

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state       <= ST_IDLE;
      ser_start_o <= 1'b0;
      ser_data_o  <= '0;
      ser_chan_o  <= '0;
      pend        <= '0;
      data_lost_o <= 1'b0;
      ack_err_o   <= 1'b0;
      last        <= CH_W'(CHANNELS - 1);
      timer       <= '0;
      for (int c = 0; c < CHANNELS; c++) hold[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (valid_i[c]) hold[c] <= data_i;
      end
      // A valid on the dispatched channel re-arms it (set wins over clear).
      pend        <= (pend & ~disp_mask) | valid_i;
      data_lost_o <= |lost_mask;

      case (state)
        ST_IDLE: begin
          if (dispatch) begin
            ser_data_o  <= hold[sel];
            ser_chan_o  <= sel;
            last        <= sel;
            ser_start_o <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          ser_start_o <= 1'b0;
          timer       <= '0;
          state       <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          // Timeout lands ACK_TIMEOUT cycles after ser_start_o rose.
          if (ser_busy_i) begin
            state <= ST_WAIT_DONE;
          end else if (timer == TW'(ACK_TIMEOUT - 2)) begin
            ack_err_o <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!ser_busy_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grad_ser_sched.sv
// Directed bench for grad_ser_sched with a behavioural serialiser model.
module tb_grad_ser_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_i;
  logic [3:0]  valid_i;
  logic        ser_busy_i;
  logic        ser_start_o;
  logic [31:0] ser_data_o;
  logic [1:0]  ser_chan_o;
  logic        serial_busy_o;
  logic        data_lost_o;
  logic [3:0]  pending_o;
  logic        ack_err_o;

  // serialiser model controls
  logic        model_busy = 1'b0;
  logic        busy_force = 1'b0;
  logic        ack_en     = 1'b1;
  int          ser_delay  = 20;
  int          busy_cnt   = 0;

  int total = 0;
  int bad   = 0;
  int lost_cnt = 0;
  logic early;

  logic [33:0] exp_q[$];
  logic [33:0] got_q[$];

  assign ser_busy_i = model_busy | busy_force;

  grad_ser_sched dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .data_i        (data_i),
    .valid_i       (valid_i),
    .ser_busy_i    (ser_busy_i),
    .ser_start_o   (ser_start_o),
    .ser_data_o    (ser_data_o),
    .ser_chan_o    (ser_chan_o),
    .serial_busy_o (serial_busy_o),
    .data_lost_o   (data_lost_o),
    .pending_o     (pending_o),
    .ack_err_o     (ack_err_o)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // serialiser model + monitor, on the inactive edge
  always @(negedge clk) begin
    if (ser_start_o) begin
      got_q.push_back({ser_chan_o, ser_data_o});
      if (ack_en) begin
        model_busy = 1'b1;
        busy_cnt   = ser_delay;
      end
    end else if (model_busy) begin
      busy_cnt = busy_cnt - 1;
      if (busy_cnt <= 0) model_busy = 1'b0;
    end
    if (data_lost_o) lost_cnt = lost_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_valid(input logic [3:0] v, input logic [31:0] d);
    valid_i = v;
    data_i  = d;
    tick();
    valid_i = '0;
    data_i  = '0;
  endtask

  task automatic push_exp(input logic [1:0] ch, input logic [31:0] d);
    exp_q.push_back({ch, d});
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (!serial_busy_o && ser_busy_i) early = 1'b1;
      if (!serial_busy_o && !ser_busy_i && !ser_start_o) begin
        done = 1'b1;
        break;
      end
    end
    chk("wait_idle", 64'(done), 64'd1);
  endtask

  task automatic check_log(input string tag);
    int n;
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_entry"}, 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_i = '0;
    data_i  = '0;
    tick(3);

    // reset state
    chk("rst_start", 64'(ser_start_o), 64'd0);
    chk("rst_data", 64'(ser_data_o), 64'd0);
    chk("rst_chan", 64'(ser_chan_o), 64'd0);
    chk("rst_pend", 64'(pending_o), 64'd0);
    chk("rst_sbusy", 64'(serial_busy_o), 64'd0);
    chk("rst_lost", 64'(data_lost_o), 64'd0);
    chk("rst_ackerr", 64'(ack_err_o), 64'd0);
    rst_n = 1'b1;
    tick();

    // all four channels at once, in order ch0..ch3
    ser_delay = 20;
    early     = 1'b0;
    lost_cnt  = 0;
    pulse_valid(4'b1111, 32'habcd0123);
    chk("cap_pend", 64'(pending_o), 64'hf);
    chk("cap_sbusy", 64'(serial_busy_o), 64'd1);
    chk("cap_start", 64'(ser_start_o), 64'd0);
    tick();
    chk("disp_start", 64'(ser_start_o), 64'd1);
    chk("disp_chan", 64'(ser_chan_o), 64'd0);
    chk("disp_data", 64'(ser_data_o), 64'habcd0123);
    chk("disp_pend", 64'(pending_o), 64'he);
    tick();
    chk("issue_end", 64'(ser_start_o), 64'd0);
    for (int c = 0; c < 4; c++) push_exp(2'(c), 32'habcd0123);
    wait_idle();
    check_log("all4");
    chk("all4_early_drop", 64'(early), 64'd0);
    chk("all4_lost", 64'(lost_cnt), 64'd0);

    // round-robin rotation
    ser_delay = 3;
    pulse_valid(4'b0010, 32'h101); push_exp(2'd1, 32'h101);
    wait_idle();
    pulse_valid(4'b0011, 32'h102); push_exp(2'd0, 32'h102); push_exp(2'd1, 32'h102);
    wait_idle();
    pulse_valid(4'b1000, 32'h103); push_exp(2'd3, 32'h103);
    wait_idle();
    pulse_valid(4'b0011, 32'h104); push_exp(2'd0, 32'h104); push_exp(2'd1, 32'h104);
    wait_idle();
    pulse_valid(4'b0111, 32'h105);
    push_exp(2'd2, 32'h105); push_exp(2'd0, 32'h105); push_exp(2'd1, 32'h105);
    wait_idle();
    check_log("rr");

    // overwrite of a pending word while the serialiser is busy
    ser_delay = 20;
    lost_cnt  = 0;
    pulse_valid(4'b0001, 32'h0a0a);
    tick(4);
    pulse_valid(4'b0100, 32'h1);
    chk("ovr_first_nolost", 64'(data_lost_o), 64'd0);
    pulse_valid(4'b0100, 32'h2);
    chk("ovr_lost", 64'(data_lost_o), 64'd1);
    chk("ovr_pend", 64'(pending_o), 64'h4);
    tick();
    chk("ovr_lost_pulse", 64'(data_lost_o), 64'd0);
    push_exp(2'd0, 32'h0a0a); push_exp(2'd2, 32'h2);
    wait_idle();
    check_log("ovr");
    chk("ovr_lost_cnt", 64'(lost_cnt), 64'd1);

    // new word on ch0 at its own dispatch edge
    lost_cnt = 0;
    valid_i = 4'b0001;
    data_i  = 32'h4;
    tick();
    data_i  = 32'h5;
    tick();
    valid_i = '0;
    data_i  = '0;
    chk("same_start", 64'(ser_start_o), 64'd1);
    chk("same_data", 64'(ser_data_o), 64'h4);
    chk("same_pend", 64'(pending_o), 64'h1);
    chk("same_nolost", 64'(data_lost_o), 64'd0);
    push_exp(2'd0, 32'h4); push_exp(2'd0, 32'h5);
    wait_idle();
    check_log("same");
    chk("same_lost_cnt", 64'(lost_cnt), 64'd0);

    // acknowledge timeout
    ack_en = 1'b0;
    pulse_valid(4'b0011, 32'h77);
    tick();
    chk("to_start", 64'(ser_start_o), 64'd1);
    chk("to_chan", 64'(ser_chan_o), 64'd1);
    tick(3);
    chk("to_not_yet", 64'(ack_err_o), 64'd0);
    tick();
    chk("to_err", 64'(ack_err_o), 64'd1);
    ack_en = 1'b1;
    tick();
    chk("to_next_start", 64'(ser_start_o), 64'd1);
    chk("to_next_chan", 64'(ser_chan_o), 64'd0);
    push_exp(2'd1, 32'h77); push_exp(2'd0, 32'h77);
    wait_idle();
    check_log("to");
    chk("to_sticky", 64'(ack_err_o), 64'd1);

    // reset during WAIT_DONE with two channels pending
    pulse_valid(4'b0001, 32'h33);
    tick(4);
    pulse_valid(4'b1010, 32'h44);
    chk("mr_pend_before", 64'(pending_o), 64'ha);
    busy_force = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mr_pend", 64'(pending_o), 64'd0);
    chk("mr_sbusy", 64'(serial_busy_o), 64'd0);
    chk("mr_ackerr", 64'(ack_err_o), 64'd0);
    chk("mr_start", 64'(ser_start_o), 64'd0);
    chk("mr_chan", 64'(ser_chan_o), 64'd0);
    chk("mr_data", 64'(ser_data_o), 64'd0);
    push_exp(2'd0, 32'h33);
    check_log("mr_pre");
    pulse_valid(4'b0100, 32'h9);
    tick(5);
    chk("mr_no_start_busy", 64'(got_q.size()), 64'd0);
    chk("mr_pend_held", 64'(pending_o), 64'h4);
    busy_force = 1'b0;
    push_exp(2'd2, 32'h9);
    wait_idle();
    check_log("mr_post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
